rs_param_age: RTL and testbench

- Parametrised reservation station for one functional-unit class in the out-of-order core.
- Holds dispatched instructions and captures missing source operands from an N-port common data bus (CDB).
- Issues the oldest fully-ready entry through a registered valid/ready output stage.
- Adds flush, backpressure, dispatch-cycle CDB bypass, oldest-first selection, and occupancy status.

---
 rtl/rs_param_age_if.sv | 56 +++++
 rtl/rs_param_age.sv | 231 +++++++++++++++++++++++
 tb/tb_rs_param_age.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/rs_param_age_if.sv
// Bundle of dispatch, CDB, issue and status signals for the age-ordered reservation station.
// The master side dispatches, broadcasts and consumes issues; the slave side is the station itself.
interface rs_param_age_if #(
    parameter int ENTRIES   = 4,
    parameter int CDB_PORTS = 4,
    parameter int DATA_W    = 16,
    parameter int TAG_W     = 4,
    parameter int OPC_W     = 4,
    parameter int IMM_W     = 8
);
    localparam int CNT_W = $clog2(ENTRIES + 1);

    // valid/ready: a transfer happens at a rising edge where valid & ready are both 1;
    // valid may not depend on ready, and the holder keeps its fields stable while stalled.
    logic                        flush;
    logic                        in_valid;
    logic                        in_ready;
    logic [TAG_W-1:0]            in_tag;
    logic [OPC_W-1:0]            in_opcode;
    logic [IMM_W-1:0]            in_imm;
    logic [TAG_W-1:0]            in_src1_tag;
    logic [TAG_W-1:0]            in_src2_tag;
    logic [DATA_W-1:0]           in_src1_val;
    logic [DATA_W-1:0]           in_src2_val;
    logic                        in_src1_rdy;
    logic                        in_src2_rdy;
    logic [CDB_PORTS-1:0]        cdb_valid;
    logic [CDB_PORTS*TAG_W-1:0]  cdb_tag;
    logic [CDB_PORTS*DATA_W-1:0] cdb_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [TAG_W-1:0]            out_tag;
    logic [OPC_W-1:0]            out_opcode;
    logic [IMM_W-1:0]            out_imm;
    logic [DATA_W-1:0]           out_val1;
    logic [DATA_W-1:0]           out_val2;
    logic [CNT_W-1:0]            count;
    logic                        full;
    logic                        empty;

    modport master (
        output flush, in_valid, in_tag, in_opcode, in_imm,
               in_src1_tag, in_src2_tag, in_src1_val, in_src2_val, in_src1_rdy, in_src2_rdy,
               cdb_valid, cdb_tag, cdb_data, out_ready,
        input  in_ready, out_valid, out_tag, out_opcode, out_imm, out_val1, out_val2,
               count, full, empty
    );

    modport slave (
        input  flush, in_valid, in_tag, in_opcode, in_imm,
               in_src1_tag, in_src2_tag, in_src1_val, in_src2_val, in_src1_rdy, in_src2_rdy,
               cdb_valid, cdb_tag, cdb_data, out_ready,
        output in_ready, out_valid, out_tag, out_opcode, out_imm, out_val1, out_val2,
               count, full, empty
    );
endinterface

// File: rtl/rs_param_age.sv
// Reservation station: captures operands from the CDB, issues the oldest ready entry
// through a registered valid/ready stage, with flush and occupancy status.
module rs_param_age #(
    parameter int ENTRIES   = 4,
    parameter int CDB_PORTS = 4,
    parameter int DATA_W    = 16,
    parameter int TAG_W     = 4,
    parameter int OPC_W     = 4,
    parameter int IMM_W     = 8
) (
    input logic           clk,
    input logic           rst,
    rs_param_age_if.slave bus
);
    localparam int CNT_W = $clog2(ENTRIES + 1);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] s1_rdy_q, s1_rdy_d;
    logic [ENTRIES-1:0] s2_rdy_q, s2_rdy_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [OPC_W-1:0]   opc_q    [ENTRIES];
    logic [OPC_W-1:0]   opc_d    [ENTRIES];
    logic [IMM_W-1:0]   imm_q    [ENTRIES];
    logic [IMM_W-1:0]   imm_d    [ENTRIES];
    logic [TAG_W-1:0]   s1_tag_q [ENTRIES];
    logic [TAG_W-1:0]   s1_tag_d [ENTRIES];
    logic [TAG_W-1:0]   s2_tag_q [ENTRIES];
    logic [TAG_W-1:0]   s2_tag_d [ENTRIES];
    logic [DATA_W-1:0]  s1_val_q [ENTRIES];
    logic [DATA_W-1:0]  s1_val_d [ENTRIES];
    logic [DATA_W-1:0]  s2_val_q [ENTRIES];
    logic [DATA_W-1:0]  s2_val_d [ENTRIES];
    // age_q[i][j] set means entry i was dispatched before entry j
    logic [ENTRIES-1:0] age_q    [ENTRIES];
    logic [ENTRIES-1:0] age_d    [ENTRIES];

    logic              out_valid_q, out_valid_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic [OPC_W-1:0]  out_opc_q, out_opc_d;
    logic [IMM_W-1:0]  out_imm_q, out_imm_d;
    logic [DATA_W-1:0] out_val1_q, out_val1_d;
    logic [DATA_W-1:0] out_val2_q, out_val2_d;

    logic [DATA_W:0]    wake1 [ENTRIES];
    logic [DATA_W:0]    wake2 [ENTRIES];
    logic [DATA_W:0]    byp1, byp2;
    logic [ENTRIES-1:0] cand, blocked, sel_oh;
    logic [IDX_W-1:0]   sel_idx, alloc_idx;
    logic [CNT_W-1:0]   occ;
    logic               full, any_cand, issue_fire, disp_fire;

    // MSB is the hit flag; descending scan leaves the lowest matching port's data
    function automatic logic [DATA_W:0] cdb_match(
        input logic [TAG_W-1:0]            t,
        input logic [CDB_PORTS-1:0]        v,
        input logic [CDB_PORTS*TAG_W-1:0]  tags,
        input logic [CDB_PORTS*DATA_W-1:0] data
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int k = CDB_PORTS - 1; k >= 0; k--) begin
            if (v[k] && (tags[k*TAG_W +: TAG_W] == t)) r = {1'b1, data[k*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            wake1[i] = cdb_match(s1_tag_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            wake2[i] = cdb_match(s2_tag_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        end
        byp1 = cdb_match(bus.in_src1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        byp2 = cdb_match(bus.in_src2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end

    // Oldest candidate: the one no other candidate is older than
    always_comb begin
        cand    = valid_q & s1_rdy_q & s2_rdy_q;
        blocked = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            for (int j = 0; j < ENTRIES; j++) begin
                if (cand[j] && age_q[j][i]) blocked[i] = 1'b1;
            end
        end
        sel_oh  = cand & ~blocked;
        sel_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (sel_oh[i]) sel_idx = IDX_W'(i);
        end
        alloc_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = IDX_W'(i);
        end
        occ = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            occ = occ + CNT_W'(valid_q[i]);
        end
    end

    assign full       = &valid_q;
    assign any_cand   = |cand;
    assign issue_fire = any_cand && (!out_valid_q || bus.out_ready) && !bus.flush;
    assign disp_fire  = bus.in_valid && !full && !bus.flush;

    always_comb begin
        valid_d  = valid_q;
        s1_rdy_d = s1_rdy_q;
        s2_rdy_d = s2_rdy_q;
        tag_d    = tag_q;
        opc_d    = opc_q;
        imm_d    = imm_q;
        s1_tag_d = s1_tag_q;
        s2_tag_d = s2_tag_q;
        s1_val_d = s1_val_q;
        s2_val_d = s2_val_q;
        age_d    = age_q;

        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && !s1_rdy_q[i] && wake1[i][DATA_W]) begin
                s1_rdy_d[i] = 1'b1;
                s1_val_d[i] = wake1[i][DATA_W-1:0];
            end
            if (valid_q[i] && !s2_rdy_q[i] && wake2[i][DATA_W]) begin
                s2_rdy_d[i] = 1'b1;
                s2_val_d[i] = wake2[i][DATA_W-1:0];
            end
        end

        if (issue_fire) valid_d[sel_idx] = 1'b0;

        // alloc_idx comes from registered valid bits, so it never aliases the issuing slot
        if (disp_fire) begin
            valid_d[alloc_idx]  = 1'b1;
            tag_d[alloc_idx]    = bus.in_tag;
            opc_d[alloc_idx]    = bus.in_opcode;
            imm_d[alloc_idx]    = bus.in_imm;
            s1_tag_d[alloc_idx] = bus.in_src1_tag;
            s2_tag_d[alloc_idx] = bus.in_src2_tag;
            s1_rdy_d[alloc_idx] = bus.in_src1_rdy | byp1[DATA_W];
            s2_rdy_d[alloc_idx] = bus.in_src2_rdy | byp2[DATA_W];
            s1_val_d[alloc_idx] = bus.in_src1_rdy ? bus.in_src1_val : byp1[DATA_W-1:0];
            s2_val_d[alloc_idx] = bus.in_src2_rdy ? bus.in_src2_val : byp2[DATA_W-1:0];
            for (int j = 0; j < ENTRIES; j++) begin
                age_d[j][alloc_idx] = 1'b1;
            end
            age_d[alloc_idx] = '0;
        end

        if (bus.flush) begin
            valid_d = '0;
            for (int i = 0; i < ENTRIES; i++) begin
                age_d[i] = '0;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        out_opc_d   = out_opc_q;
        out_imm_d   = out_imm_q;
        out_val1_d  = out_val1_q;
        out_val2_d  = out_val2_q;
        if (issue_fire) begin
            out_valid_d = 1'b1;
            out_tag_d   = tag_q[sel_idx];
            out_opc_d   = opc_q[sel_idx];
            out_imm_d   = imm_q[sel_idx];
            out_val1_d  = s1_val_q[sel_idx];
            out_val2_d  = s2_val_q[sel_idx];
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (bus.flush) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            s1_rdy_q    <= '0;
            s2_rdy_q    <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_opc_q   <= '0;
            out_imm_q   <= '0;
            out_val1_q  <= '0;
            out_val2_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                opc_q[i]    <= '0;
                imm_q[i]    <= '0;
                s1_tag_q[i] <= '0;
                s2_tag_q[i] <= '0;
                s1_val_q[i] <= '0;
                s2_val_q[i] <= '0;
                age_q[i]    <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            s1_rdy_q    <= s1_rdy_d;
            s2_rdy_q    <= s2_rdy_d;
            tag_q       <= tag_d;
            opc_q       <= opc_d;
            imm_q       <= imm_d;
            s1_tag_q    <= s1_tag_d;
            s2_tag_q    <= s2_tag_d;
            s1_val_q    <= s1_val_d;
            s2_val_q    <= s2_val_d;
            age_q       <= age_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_opc_q   <= out_opc_d;
            out_imm_q   <= out_imm_d;
            out_val1_q  <= out_val1_d;
            out_val2_q  <= out_val2_d;
        end
    end

    assign bus.in_ready   = ~full;
    assign bus.full       = full;
    assign bus.empty      = ~|valid_q;
    assign bus.count      = occ;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.out_opcode = out_opc_q;
    assign bus.out_imm    = out_imm_q;
    assign bus.out_val1   = out_val1_q;
    assign bus.out_val2   = out_val2_q;
endmodule

// File: tb/tb_rs_param_age.sv
// Directed bench for rs_param_age: ordering, wakeup, dispatch bypass, full, stall, flush, reset.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_rs_param_age;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rs_param_age_if #(.ENTRIES(4), .CDB_PORTS(4), .DATA_W(16), .TAG_W(4), .OPC_W(4), .IMM_W(8)) bus ();

    rs_param_age #(.ENTRIES(4), .CDB_PORTS(4), .DATA_W(16), .TAG_W(4), .OPC_W(4), .IMM_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.cdb_valid = '0;
        bus.flush     = 1'b0;
    endtask

    // opcode and immediate are derived from the tag so each issue is self-describing
    task automatic dispatch(input logic [3:0] tag, input logic [15:0] v1, input logic r1, input logic [3:0] t1,
                            input logic [15:0] v2, input logic r2, input logic [3:0] t2);
        bus.in_valid    = 1'b1;
        bus.in_tag      = tag;
        bus.in_opcode   = tag ^ 4'hA;
        bus.in_imm      = {tag, tag};
        bus.in_src1_val = v1;
        bus.in_src1_rdy = r1;
        bus.in_src1_tag = t1;
        bus.in_src2_val = v2;
        bus.in_src2_rdy = r2;
        bus.in_src2_tag = t2;
    endtask

    task automatic cdb_send(input int port, input logic [3:0] tag, input logic [15:0] data);
        bus.cdb_valid[port]           = 1'b1;
        bus.cdb_tag[port*4 +: 4]      = tag;
        bus.cdb_data[port*16 +: 16]   = data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.out_ready = 1'b1;
        bus.in_tag = '0; bus.in_opcode = '0; bus.in_imm = '0;
        bus.in_src1_tag = '0; bus.in_src2_tag = '0; bus.in_src1_val = '0; bus.in_src2_val = '0;
        bus.in_src1_rdy = 1'b0; bus.in_src2_rdy = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
        tick();
        tick();
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", bus.full); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_tag !== 4'd0 || bus.out_val1 !== 16'd0) begin errors++; $display("FAIL reset_out_data: got tag %0d val1 %h exp 0 0", bus.out_tag, bus.out_val1); end
        rst = 1'b0;
        tick();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_release_empty: got %b exp 1", bus.empty); end
    endtask

    task automatic test_in_order();
        bus.out_ready = 1'b1;
        dispatch(4'd1, 16'h0101, 1'b1, 4'd0, 16'h0102, 1'b1, 4'd0);
        tick();
        checks++; if (bus.count !== 3'd1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL order_first: got count %0d valid %b exp 1 0", bus.count, bus.out_valid); end
        dispatch(4'd2, 16'h0201, 1'b1, 4'd0, 16'h0202, 1'b1, 4'd0);
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd1) begin errors++; $display("FAIL order_tag1: got valid %b tag %0d exp 1 1", bus.out_valid, bus.out_tag); end
        checks++; if (bus.out_val1 !== 16'h0101 || bus.out_val2 !== 16'h0102) begin errors++; $display("FAIL order_vals1: got %h %h exp 0101 0102", bus.out_val1, bus.out_val2); end
        checks++; if (bus.out_opcode !== 4'hB || bus.out_imm !== 8'h11) begin errors++; $display("FAIL order_opc_imm: got %h %h exp b 11", bus.out_opcode, bus.out_imm); end
        dispatch(4'd3, 16'h0301, 1'b1, 4'd0, 16'h0302, 1'b1, 4'd0);
        tick();
        checks++; if (bus.out_tag !== 4'd2 || bus.out_val1 !== 16'h0201) begin errors++; $display("FAIL order_tag2: got tag %0d val1 %h exp 2 0201", bus.out_tag, bus.out_val1); end
        idle();
        tick();
        checks++; if (bus.out_tag !== 4'd3 || bus.out_val2 !== 16'h0302 || bus.count !== 3'd0) begin errors++; $display("FAIL order_tag3: got tag %0d val2 %h count %0d exp 3 0302 0", bus.out_tag, bus.out_val2, bus.count); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL order_drain: got valid %b empty %b exp 0 1", bus.out_valid, bus.empty); end
    endtask

    task automatic test_wakeup();
        bus.out_ready = 1'b1;
        dispatch(4'd5, 16'h0000, 1'b0, 4'd9, 16'h0055, 1'b1, 4'd0);
        tick();
        idle();
        checks++; if (bus.count !== 3'd1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL wake_wait: got count %0d valid %b exp 1 0", bus.count, bus.out_valid); end
        cdb_send(3, 4'd9, 16'h9999);
        cdb_send(2, 4'd9, 16'h1234);
        cdb_send(1, 4'd3, 16'hDEAD);
        tick();
        idle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL wake_early: got valid %b exp 0", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd5) begin errors++; $display("FAIL wake_issue: got valid %b tag %0d exp 1 5", bus.out_valid, bus.out_tag); end
        checks++; if (bus.out_val1 !== 16'h1234 || bus.out_val2 !== 16'h0055) begin errors++; $display("FAIL wake_vals: got %h %h exp 1234 0055", bus.out_val1, bus.out_val2); end
        tick();
    endtask

    task automatic test_bypass();
        bus.out_ready = 1'b1;
        dispatch(4'd6, 16'h0066, 1'b1, 4'd0, 16'h0000, 1'b0, 4'd7);
        cdb_send(0, 4'd7, 16'hBEEF);
        tick();
        idle();
        checks++; if (bus.count !== 3'd1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bypass_dispatch: got count %0d valid %b exp 1 0", bus.count, bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd6 || bus.out_val2 !== 16'hBEEF || bus.out_val1 !== 16'h0066) begin errors++; $display("FAIL bypass_issue: got valid %b tag %0d vals %h %h exp 1 6 0066 beef", bus.out_valid, bus.out_tag, bus.out_val1, bus.out_val2); end
        tick();
    endtask

    task automatic test_full();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dispatch(4'(8 + i), 16'h0000, 1'b0, 4'(12 + i), 16'(16'h00A0 + i), 1'b1, 4'd0);
            tick();
        end
        checks++; if (bus.count !== 3'd4 || bus.full !== 1'b1 || bus.in_ready !== 1'b0 || bus.empty !== 1'b0) begin errors++; $display("FAIL full_status: got count %0d full %b in_ready %b empty %b exp 4 1 0 0", bus.count, bus.full, bus.in_ready, bus.empty); end
        dispatch(4'd12, 16'h0C0C, 1'b1, 4'd0, 16'h0C0D, 1'b1, 4'd0);
        tick();
        idle();
        checks++; if (bus.count !== 3'd4 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_drop: got count %0d valid %b exp 4 0", bus.count, bus.out_valid); end
        cdb_send(1, 4'd14, 16'h0A0A);
        tick();
        idle();
        checks++; if (bus.count !== 3'd4 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_woken: got count %0d valid %b exp 4 0", bus.count, bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd10 || bus.out_val1 !== 16'h0A0A || bus.out_val2 !== 16'h00A2) begin errors++; $display("FAIL full_issue: got valid %b tag %0d vals %h %h exp 1 10 0a0a 00a2", bus.out_valid, bus.out_tag, bus.out_val1, bus.out_val2); end
        checks++; if (bus.count !== 3'd3 || bus.full !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_release: got count %0d full %b in_ready %b exp 3 0 1", bus.count, bus.full, bus.in_ready); end
        bus.flush = 1'b1;
        tick();
        idle();
        checks++; if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_cleanup: got empty %b valid %b exp 1 0", bus.empty, bus.out_valid); end
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        dispatch(4'd1, 16'h1111, 1'b1, 4'd0, 16'h1112, 1'b1, 4'd0);
        tick();
        dispatch(4'd2, 16'h2221, 1'b1, 4'd0, 16'h2222, 1'b1, 4'd0);
        tick();
        dispatch(4'd3, 16'h3331, 1'b1, 4'd0, 16'h3332, 1'b1, 4'd0);
        tick();
        idle();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd1 || bus.count !== 3'd2) begin errors++; $display("FAIL stall_load: got valid %b tag %0d count %0d exp 1 1 2", bus.out_valid, bus.out_tag, bus.count); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd1 || bus.out_val1 !== 16'h1111 || bus.count !== 3'd2) begin errors++; $display("FAIL stall_hold%0d: got valid %b tag %0d val1 %h count %0d exp 1 1 1111 2", c, bus.out_valid, bus.out_tag, bus.out_val1, bus.count); end
        end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_tag !== 4'd2 || bus.out_val1 !== 16'h2221 || bus.count !== 3'd1) begin errors++; $display("FAIL stall_oldest: got tag %0d val1 %h count %0d exp 2 2221 1", bus.out_tag, bus.out_val1, bus.count); end
        tick();
        checks++; if (bus.out_tag !== 4'd3 || bus.out_val2 !== 16'h3332 || bus.count !== 3'd0) begin errors++; $display("FAIL stall_younger: got tag %0d val2 %h count %0d exp 3 3332 0", bus.out_tag, bus.out_val2, bus.count); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got valid %b exp 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dispatch(4'(4 + i), 16'(16'h4000 + i), 1'b1, 4'd0, 16'h0001, 1'b1, 4'd0);
            tick();
        end
        idle();
        checks++; if (bus.count !== 3'd3 || bus.out_valid !== 1'b1 || bus.out_tag !== 4'd4) begin errors++; $display("FAIL flush_pre: got count %0d valid %b tag %0d exp 3 1 4", bus.count, bus.out_valid, bus.out_tag); end
        bus.flush = 1'b1;
        dispatch(4'd8, 16'h8888, 1'b1, 4'd0, 16'h8889, 1'b1, 4'd0);
        tick();
        idle();
        checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got count %0d empty %b valid %b exp 0 1 0", bus.count, bus.empty, bus.out_valid); end
        tick();
        checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_after: got count %0d valid %b exp 0 0", bus.count, bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        dispatch(4'd1, 16'h5151, 1'b1, 4'd0, 16'h5152, 1'b1, 4'd0);
        tick();
        dispatch(4'd2, 16'h5251, 1'b1, 4'd0, 16'h5252, 1'b1, 4'd0);
        tick();
        dispatch(4'd3, 16'h5351, 1'b1, 4'd0, 16'h5352, 1'b1, 4'd0);
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.count !== 3'd2) begin errors++; $display("FAIL rstmid_pre: got valid %b count %0d exp 1 2", bus.out_valid, bus.count); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_status: got valid %b count %0d empty %b full %b in_ready %b exp 0 0 1 0 1", bus.out_valid, bus.count, bus.empty, bus.full, bus.in_ready); end
        checks++; if (bus.out_tag !== 4'd0 || bus.out_val1 !== 16'd0 || bus.out_val2 !== 16'd0 || bus.out_opcode !== 4'd0 || bus.out_imm !== 8'd0) begin errors++; $display("FAIL rstmid_data: got tag %0d vals %h %h opc %h imm %h exp all 0", bus.out_tag, bus.out_val1, bus.out_val2, bus.out_opcode, bus.out_imm); end
        idle();
        #2;
        rst = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL rstmid_release: got valid %b count %0d exp 0 0", bus.out_valid, bus.count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_in_order();
        test_wakeup();
        test_bypass();
        test_full();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
